// File: rtl/stack_ctrl.sv
// stack_ctrl: request-side controller for an 8-bit x 4-deep shift stack with replace sequencing and sticky errors
module stack_ctrl #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int DW   = $clog2(DEPTH + 1)
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          push_req,
    input  logic          pop_req,
    input  logic [W-1:0]  push_data,
    output logic          req_ready,
    input  logic [W-1:0]  stk_top,
    output logic [1:0]    stk_s,
    output logic [W-1:0]  stk_i,
    output logic [W-1:0]  pop_data,
    output logic          pop_valid,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty,
    output logic          ovf_err,
    output logic          unf_err,
    input  logic          err_clr
);
    typedef enum logic {IDLE, REPL} state_t;

    state_t        state, state_n;
    logic [DW-1:0] depth_n;
    logic [W-1:0]  hold;
    logic          do_pop, load, ovf_set, unf_set;

    assign req_ready = (state == IDLE) && !rst;
    assign full      = depth == DW'(DEPTH);
    assign empty     = depth == '0;

    // decode the accepted request into a stack op, next state and error events
    always_comb begin
        stk_s   = 2'b00;
        stk_i   = push_data;
        state_n = state;
        depth_n = depth;
        do_pop  = 1'b0;
        load    = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (state == REPL && !rst) begin
            stk_s   = 2'b10;
            stk_i   = hold;
            state_n = IDLE;
        end else if (req_ready) begin
            if (push_req && pop_req) begin
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    stk_s   = 2'b01;
                    do_pop  = 1'b1;
                    load    = 1'b1;
                    state_n = REPL;
                end
            end else if (push_req) begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    stk_s   = 2'b10;
                    depth_n = depth + DW'(1);
                end
            end else if (pop_req) begin
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    stk_s   = 2'b01;
                    do_pop  = 1'b1;
                    depth_n = depth - DW'(1);
                end
            end
        end
    end

    // state, occupancy, popped data and sticky errors (a new error beats err_clr)
    always_ff @(posedge ck) begin
        if (rst) begin
            state     <= IDLE;
            depth     <= '0;
            hold      <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            ovf_err   <= 1'b0;
            unf_err   <= 1'b0;
        end else begin
            state     <= state_n;
            depth     <= depth_n;
            pop_valid <= do_pop;
            if (do_pop) pop_data <= stk_top;
            if (load) hold <= push_data;
            ovf_err   <= ovf_set || (ovf_err && !err_clr);
            unf_err   <= unf_set || (unf_err && !err_clr);
        end
    end
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed and randomized checks of stack_ctrl against a queue-based reference model
module tb_stack_ctrl;
    logic       ck = 0, rst = 1, push_req = 0, pop_req = 0, err_clr = 0;
    logic [7:0] push_data = 0;
    logic [7:0] stk_top, stk_i, pop_data;
    logic [1:0] stk_s;
    logic [2:0] depth;
    logic       req_ready, pop_valid, full, empty, ovf_err, unf_err;
    int         checks = 0, errors = 0;

    // environment: the 4-deep shift stack the controller drives
    logic [7:0] stk [4] = '{default: 8'h00};
    assign stk_top = stk[0];

    // clock generator
    always #5 ck = ~ck;

    // shift stack behaviour: push shifts down, pop shifts up
    always @(posedge ck) begin
        if (stk_s == 2'b10) begin
            stk[3] <= stk[2]; stk[2] <= stk[1]; stk[1] <= stk[0]; stk[0] <= stk_i;
        end else if (stk_s == 2'b01) begin
            stk[0] <= stk[1]; stk[1] <= stk[2]; stk[2] <= stk[3]; stk[3] <= 8'h00;
        end
    end

    stack_ctrl dut (
        .ck(ck), .rst(rst), .push_req(push_req), .pop_req(pop_req), .push_data(push_data),
        .req_ready(req_ready), .stk_top(stk_top), .stk_s(stk_s), .stk_i(stk_i),
        .pop_data(pop_data), .pop_valid(pop_valid), .depth(depth), .full(full), .empty(empty),
        .ovf_err(ovf_err), .unf_err(unf_err), .err_clr(err_clr)
    );

    // reference model: queue front is top of stack; pend marks a replace awaiting its push
    logic [7:0] q[$];
    bit         pend, m_ovf, m_unf, m_pv;
    logic [7:0] pend_d, m_pd;
    logic [1:0] m_s;

    task automatic drive(input bit r, input bit p, input bit o, input logic [7:0] d, input bit c);
        bit no, nu;
        @(negedge ck);
        rst = r; push_req = p; pop_req = o; push_data = d; err_clr = c;
        #1;
        no = 0; nu = 0; m_pv = 0; m_s = 2'b00;
        if (r) begin
            q.delete(); pend = 0; m_ovf = 0; m_unf = 0; m_pd = 8'h00;
        end else begin
            if (pend) begin
                m_s = 2'b10; q.push_front(pend_d); pend = 0;
            end else if (p && o) begin
                if (q.size() == 0) nu = 1;
                else begin m_s = 2'b01; m_pd = q.pop_front(); m_pv = 1; pend = 1; pend_d = d; end
            end else if (p) begin
                if (q.size() == 4) no = 1;
                else begin m_s = 2'b10; q.push_front(d); end
            end else if (o) begin
                if (q.size() == 0) nu = 1;
                else begin m_s = 2'b01; m_pd = q.pop_front(); m_pv = 1; end
            end
            m_ovf = no || (m_ovf && !c);
            m_unf = nu || (m_unf && !c);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 0, 8'hAA, 0);
        checks++; if (stk_s !== 2'b00) begin errors++; $display("FAIL reset_stk_s got %b exp 00", stk_s); end
        tick();
        checks++; if (depth !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_depth got %0d/%b/%b exp 0/1/0", depth, empty, full); end
        checks++; if (pop_valid !== 1'b0 || pop_data !== 8'h00) begin errors++; $display("FAIL reset_pop got %b/%h exp 0/00", pop_valid, pop_data); end
        checks++; if (ovf_err !== 1'b0 || unf_err !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b%b exp 000", ovf_err, unf_err, req_ready); end
        drive(0, 0, 0, 8'h00, 0);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        tick();
    endtask

    task automatic test_fill();
        logic [7:0] v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, v[i], 0);
            checks++; if (stk_s !== 2'b10 || stk_i !== v[i]) begin errors++; $display("FAIL fill_op got %b/%h exp 10/%h", stk_s, stk_i, v[i]); end
            tick();
        end
        checks++; if (depth !== 3'd4 || full !== 1'b1 || stk_top !== 8'h44) begin errors++; $display("FAIL fill_state got %0d/%b/%h exp 4/1/44", depth, full, stk_top); end
        checks++; if (ovf_err !== 1'b0 || unf_err !== 1'b0) begin errors++; $display("FAIL fill_err got %b%b exp 00", ovf_err, unf_err); end
    endtask

    task automatic test_overflow();
        drive(0, 1, 0, 8'h55, 0);
        checks++; if (stk_s !== 2'b00) begin errors++; $display("FAIL ovf_op got %b exp 00", stk_s); end
        tick();
        checks++; if (ovf_err !== 1'b1 || depth !== 3'd4 || stk_top !== 8'h44) begin errors++; $display("FAIL ovf_state got %b/%0d/%h exp 1/4/44", ovf_err, depth, stk_top); end
        drive(0, 0, 0, 8'h00, 1);
        tick();
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", ovf_err); end
    endtask

    task automatic test_pop();
        logic [7:0] v [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 8'h00, 0);
            checks++; if (stk_s !== 2'b01) begin errors++; $display("FAIL pop_op got %b exp 01", stk_s); end
            tick();
            checks++; if (pop_valid !== 1'b1 || pop_data !== v[i]) begin errors++; $display("FAIL pop_data got %b/%h exp 1/%h", pop_valid, pop_data, v[i]); end
        end
        drive(0, 0, 0, 8'h00, 0);
        tick();
        checks++; if (pop_valid !== 1'b0 || empty !== 1'b1 || depth !== 3'd0) begin errors++; $display("FAIL pop_end got %b/%b/%0d exp 0/1/0", pop_valid, empty, depth); end
    endtask

    task automatic test_underflow();
        drive(0, 0, 1, 8'h00, 0);
        checks++; if (stk_s !== 2'b00) begin errors++; $display("FAIL unf_op got %b exp 00", stk_s); end
        tick();
        checks++; if (unf_err !== 1'b1 || pop_valid !== 1'b0) begin errors++; $display("FAIL unf_set got %b/%b exp 1/0", unf_err, pop_valid); end
        drive(0, 0, 0, 8'h00, 1);
        tick();
        checks++; if (unf_err !== 1'b0) begin errors++; $display("FAIL unf_clr got %b exp 0", unf_err); end
        drive(0, 1, 1, 8'h66, 1);
        tick();
        checks++; if (unf_err !== 1'b1 || depth !== 3'd0) begin errors++; $display("FAIL unf_set_wins got %b/%0d exp 1/0", unf_err, depth); end
        drive(0, 0, 0, 8'h00, 1);
        tick();
    endtask

    task automatic test_replace();
        drive(0, 1, 0, 8'h11, 0); tick();
        drive(0, 1, 0, 8'h22, 0); tick();
        drive(0, 1, 1, 8'h99, 0);
        checks++; if (stk_s !== 2'b01) begin errors++; $display("FAIL repl_pop_op got %b exp 01", stk_s); end
        tick();
        checks++; if (pop_valid !== 1'b1 || pop_data !== 8'h22 || req_ready !== 1'b0) begin errors++; $display("FAIL repl_pop got %b/%h/%b exp 1/22/0", pop_valid, pop_data, req_ready); end
        checks++; if (stk_s !== 2'b10 || stk_i !== 8'h99) begin errors++; $display("FAIL repl_push_op got %b/%h exp 10/99", stk_s, stk_i); end
        drive(0, 0, 0, 8'h00, 0);
        tick();
        checks++; if (stk_top !== 8'h99 || depth !== 3'd2 || req_ready !== 1'b1 || pop_valid !== 1'b0) begin errors++; $display("FAIL repl_done got %h/%0d/%b/%b exp 99/2/1/0", stk_top, depth, req_ready, pop_valid); end
        checks++; if (ovf_err !== 1'b0 || unf_err !== 1'b0) begin errors++; $display("FAIL repl_err got %b%b exp 00", ovf_err, unf_err); end
    endtask

    task automatic test_reset_repl();
        drive(0, 1, 1, 8'h77, 0);
        tick();
        drive(1, 0, 0, 8'h00, 0);
        checks++; if (stk_s !== 2'b00) begin errors++; $display("FAIL rrepl_op got %b exp 00", stk_s); end
        tick();
        drive(0, 0, 0, 8'h00, 0);
        checks++; if (depth !== 3'd0 || req_ready !== 1'b1 || stk_s !== 2'b00) begin errors++; $display("FAIL rrepl_state got %0d/%b/%b exp 0/1/00", depth, req_ready, stk_s); end
        tick();
        checks++; if (stk_top !== 8'h11) begin errors++; $display("FAIL rrepl_no_push got %h exp 11", stk_top); end
    endtask

    task automatic test_random();
        bit r, p, o, c;
        logic [7:0] d;
        drive(1, 0, 0, 8'h00, 0); tick();
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 49) == 0);
            p = $urandom_range(0, 1);
            o = $urandom_range(0, 1);
            c = ($urandom_range(0, 7) == 0);
            d = 8'($urandom);
            drive(r, p, o, d, c);
            checks++; if (stk_s !== m_s) begin errors++; $display("FAIL rnd_stk_s n=%0d got %b exp %b", n, stk_s, m_s); end
            tick();
            checks++; if (depth !== 3'(q.size() + int'(pend))) begin errors++; $display("FAIL rnd_depth n=%0d got %0d exp %0d", n, depth, q.size() + int'(pend)); end
            checks++; if (full !== (q.size() + int'(pend) == 4) || empty !== (q.size() + int'(pend) == 0)) begin errors++; $display("FAIL rnd_full_empty n=%0d got %b%b", n, full, empty); end
            checks++; if (pop_valid !== m_pv || pop_data !== m_pd) begin errors++; $display("FAIL rnd_pop n=%0d got %b/%h exp %b/%h", n, pop_valid, pop_data, m_pv, m_pd); end
            checks++; if (ovf_err !== m_ovf || unf_err !== m_unf) begin errors++; $display("FAIL rnd_err n=%0d got %b%b exp %b%b", n, ovf_err, unf_err, m_ovf, m_unf); end
            checks++; if (req_ready !== (!pend && !r)) begin errors++; $display("FAIL rnd_ready n=%0d got %b exp %b", n, req_ready, !pend && !r); end
            if (q.size() > 0) begin
                checks++; if (stk_top !== q[0]) begin errors++; $display("FAIL rnd_top n=%0d got %h exp %h", n, stk_top, q[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_pop();
        test_underflow();
        test_replace();
        test_reset_repl();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
